// File: rtl/sw_input_ctrl.sv
// rtl/sw_input_ctrl.sv - MMIO slide-switch controller: sync, debounce, change mask, level irq
//
// Optional feature macro: SW_COMMIT_CNT_EN
//   defined   : 16-bit wrapping commit counter readable at +0xC, cleared by any write to +0xC
//   undefined : +0xC is unmapped and no counter logic is built

module sw_input_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFFF070,
    parameter int          SW_W      = 24,
    parameter int          DB_CYCLES = 100000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     addr,
    input  logic            rd,
    input  logic            wr,
    input  logic [31:0]     wdata,
    input  logic [SW_W-1:0] sw,
    output logic [31:0]     rdata,
    output logic            irq
);

    localparam int                CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // Synchroniser, debounce and register state
    logic [SW_W-1:0]  r_sync1;
    logic [SW_W-1:0]  r_sync2;
    logic [SW_W-1:0]  r_stable;
    logic [SW_W-1:0]  r_cand;
    logic [SW_W-1:0]  r_chg;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    logic             r_irq_en;
    logic [31:0]      r_rdata;
    logic             r_irq;

    // FSM next-state signals
    state_t           w_state_next;
    logic [SW_W-1:0]  w_cand_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_commit;

    // Bus decode
    logic             w_in_window;
    logic [1:0]       w_off;
    logic             w_mapped;
    logic             w_rd_chg;
    logic             w_wr_ctrl;
    logic [31:0]      w_rd_val;
    logic [SW_W-1:0]  w_chg_next;
    logic             w_unused;

    assign w_in_window = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_off       = addr[3:2];
    assign w_rd_chg    = rd && w_in_window && (w_off == 2'd1);
    assign w_wr_ctrl   = wr && w_in_window && (w_off == 2'd2);
    assign w_commit    = (r_state == S_COMMIT);

`ifdef SW_COMMIT_CNT_EN
    logic [15:0] r_commit_cnt;
    logic        w_wr_cnt;

    assign w_mapped = w_in_window;
    assign w_wr_cnt = wr && w_in_window && (w_off == 2'd3);
`else
    assign w_mapped = w_in_window && (w_off != 2'd3);
`endif

    // Byte-lane bits of the address and upper write-data bits have no function here
    assign w_unused = ^{addr[1:0], wdata[31:1]};

    // Two-flop synchroniser on the raw switch pins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM next-state: candidate must hold DB_CYCLES counts before commit
    always_comb begin
        w_state_next = r_state;
        w_cand_next  = r_cand;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (r_sync2 != r_stable) begin
                    w_cand_next  = r_sync2;
                    w_cnt_next   = '0;
                    w_state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                if (r_sync2 == r_stable) begin
                    w_state_next = S_IDLE;
                end else if (r_sync2 != r_cand) begin
                    w_cand_next = r_sync2;
                    w_cnt_next  = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = S_COMMIT;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_COMMIT: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Debounce FSM state, candidate and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cand  <= w_cand_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Change mask: a CHG read clears old bits, but bits from a same-cycle commit survive
    always_comb begin
        w_chg_next = w_rd_chg ? '0 : r_chg;
        if (w_commit) begin
            w_chg_next = w_chg_next | (r_stable ^ r_cand);
        end
    end

    // Stable value, change mask and interrupt enable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable <= '0;
            r_chg    <= '0;
            r_irq_en <= 1'b0;
        end else begin
            if (w_commit) begin
                r_stable <= r_cand;
            end
            r_chg <= w_chg_next;
            if (w_wr_ctrl) begin
                r_irq_en <= wdata[0];
            end
        end
    end

`ifdef SW_COMMIT_CNT_EN
    // Commit counter: a write clears it, a commit in the same cycle still counts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_commit_cnt <= '0;
        end else if (w_wr_cnt) begin
            r_commit_cnt <= w_commit ? 16'd1 : 16'd0;
        end else if (w_commit) begin
            r_commit_cnt <= r_commit_cnt + 16'd1;
        end
    end
`endif

    // Read mux from pre-update register values
    always_comb begin
        w_rd_val = '0;
        case (w_off)
            2'd0: w_rd_val = 32'(r_stable);
            2'd1: w_rd_val = 32'(r_chg);
            2'd2: w_rd_val = {31'd0, r_irq_en};
`ifdef SW_COMMIT_CNT_EN
            2'd3: w_rd_val = {16'd0, r_commit_cnt};
`endif
            default: w_rd_val = '0;
        endcase
    end

    // Registered read data (holds on idle or unmapped access) and level interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (rd && w_mapped) begin
                r_rdata <= w_rd_val;
            end
            r_irq <= r_irq_en & (|w_chg_next);
        end
    end

    assign rdata = r_rdata;
    assign irq   = r_irq;

endmodule
